// File: rtl/display_arbitro.sv
// display_arbitro: round-robin owner of the 8-digit display plus digit-refresh prescaler
//   reloj, reinicio_n      clock, asynchronous active-low reset
//   sol[2:0], dato0..2     level requests and values of sources 0..2
//   ack[2:0]               one-cycle grant pulse, one-hot or zero
//   resultado_out, fuente  displayed word and its source (3 = none since reset)
//   ocupado                minimum-hold timer running
//   tick_refresco          one-cycle digit-advance strobe every DIV_REFRESCO cycles
module display_arbitro #(
    parameter int TIEMPO_MIN   = 50_000_000,
    parameter int DIV_REFRESCO = 100_000
) (
    input  logic        reloj,
    input  logic        reinicio_n,
    input  logic [2:0]  sol,
    input  logic [31:0] dato0,
    input  logic [31:0] dato1,
    input  logic [31:0] dato2,
    output logic [2:0]  ack,
    output logic [31:0] resultado_out,
    output logic [1:0]  fuente,
    output logic        ocupado,
    output logic        tick_refresco
);
    localparam int TW = TIEMPO_MIN > 1 ? $clog2(TIEMPO_MIN) : 1;
    localparam int PW = DIV_REFRESCO > 1 ? $clog2(DIV_REFRESCO) : 1;
    typedef enum logic {LIBRE, MOSTRAR} estado_t;
    estado_t st, st_n;
    logic [1:0] ptr, ptr_n, g0, g1, g2, gnt, fue_n;
    logic [TW-1:0] tmr, tmr_n;
    logic [PW-1:0] pre;
    logic [31:0] res_n, dg, df;
    logic [2:0] msk, ack_n;
    logic [3:0] mskx;
    // a source's own ack hides its still-high request for that cycle
    assign msk  = sol & ~ack;
    assign mskx = {1'b0, msk};
    assign g0   = ptr;
    assign g1   = ptr == 2'd2 ? 2'd0 : ptr + 2'd1;
    assign g2   = ptr == 2'd0 ? 2'd2 : ptr - 2'd1;
    assign gnt  = msk[g0] ? g0 : msk[g1] ? g1 : g2;
    assign dg   = gnt == 2'd0 ? dato0 : gnt == 2'd1 ? dato1 : dato2;
    assign df   = fuente == 2'd0 ? dato0 : fuente == 2'd1 ? dato1 : dato2;
    assign ocupado = st == MOSTRAR;
    always_comb begin
        st_n  = st;
        ptr_n = ptr;
        tmr_n = tmr;
        res_n = resultado_out;
        fue_n = fuente;
        ack_n = '0;
        // LIBRE always has tmr == 0, so expiry and idle share one arbitration path
        if (st == LIBRE || tmr == '0) begin
            st_n = |msk ? MOSTRAR : LIBRE;
            if (|msk) begin
                ptr_n = gnt == 2'd2 ? 2'd0 : gnt + 2'd1;
                tmr_n = TW'(TIEMPO_MIN - 1);
                res_n = dg;
                fue_n = gnt;
                ack_n = 3'b001 << gnt;
            end
        end else begin
            tmr_n = tmr - 1'b1;
            if (mskx[fuente]) begin
                res_n = df;
                ack_n = 3'b001 << fuente;
            end
        end
    end
    always_ff @(posedge reloj or negedge reinicio_n) begin
        if (!reinicio_n) begin
            st            <= LIBRE;
            ptr           <= '0;
            tmr           <= '0;
            resultado_out <= '0;
            fuente        <= 2'd3;
            ack           <= '0;
        end else begin
            st            <= st_n;
            ptr           <= ptr_n;
            tmr           <= tmr_n;
            resultado_out <= res_n;
            fuente        <= fue_n;
            ack           <= ack_n;
        end
    end
    always_ff @(posedge reloj or negedge reinicio_n) begin
        if (!reinicio_n) begin
            pre           <= '0;
            tick_refresco <= 1'b0;
        end else begin
            pre           <= pre == PW'(DIV_REFRESCO - 1) ? '0 : pre + 1'b1;
            tick_refresco <= pre == PW'(DIV_REFRESCO - 1);
        end
    end
endmodule

// File: tb/tb_display_arbitro.sv
// tb_display_arbitro: directed checks of arbitration, hold, refresh, masking and reset
module tb_display_arbitro;
    logic        reloj = 1'b0;
    logic        reinicio_n;
    logic [2:0]  sol;
    logic [31:0] dato0, dato1, dato2;
    logic [2:0]  ack;
    logic [31:0] resultado_out;
    logic [1:0]  fuente;
    logic        ocupado, tick_refresco;
    int n_chk = 0;
    int n_fail = 0;

    display_arbitro #(.TIEMPO_MIN(4), .DIV_REFRESCO(3)) dut (
        .reloj(reloj), .reinicio_n(reinicio_n), .sol(sol),
        .dato0(dato0), .dato1(dato1), .dato2(dato2),
        .ack(ack), .resultado_out(resultado_out), .fuente(fuente),
        .ocupado(ocupado), .tick_refresco(tick_refresco)
    );

    always #5 reloj = ~reloj;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_chk++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic cyc();
        @(negedge reloj);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " res"}, resultado_out, 32'h0);
        chk({tag, " fuente"}, 32'(fuente), 32'd3);
        chk({tag, " ack"}, 32'(ack), 32'd0);
        chk({tag, " ocupado"}, 32'(ocupado), 32'd0);
        chk({tag, " tick"}, 32'(tick_refresco), 32'd0);
    endtask

    initial begin
        reinicio_n = 1'b1;
        sol = '0;
        dato0 = 32'h12345678;
        dato1 = 32'h11111111;
        dato2 = 32'h22222222;
        #1 reinicio_n = 1'b0;
        cyc();
        cyc();
        chk_reset("reset");
        reinicio_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            cyc();
            chk($sformatf("tick c%0d", i), 32'(tick_refresco), (i % 3 == 0) ? 32'd1 : 32'd0);
            chk("idle ack", 32'(ack), 32'd0);
        end
        // single grant to source 0, hold for 4 cycles then LIBRE
        sol = 3'b001;
        cyc();
        chk("g0 ack", 32'(ack), 32'b001);
        chk("g0 res", resultado_out, 32'h12345678);
        chk("g0 fuente", 32'(fuente), 32'd0);
        chk("g0 ocupado", 32'(ocupado), 32'd1);
        sol = '0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("g0 hold ack", 32'(ack), 32'd0);
            chk("g0 hold ocupado", 32'(ocupado), 32'd1);
        end
        cyc();
        chk("g0 libre", 32'(ocupado), 32'd0);
        chk("g0 keep res", resultado_out, 32'h12345678);
        chk("g0 keep fuente", 32'(fuente), 32'd0);
        // fresh pointer, then all three request: back-to-back 0,1,2
        reinicio_n = 1'b0;
        cyc();
        reinicio_n = 1'b1;
        sol = 3'b111;
        cyc();
        chk("rr0 ack", 32'(ack), 32'b001);
        chk("rr0 fuente", 32'(fuente), 32'd0);
        sol[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rr0 wait ack", 32'(ack), 32'd0);
        end
        cyc();
        chk("rr1 ack", 32'(ack), 32'b010);
        chk("rr1 fuente", 32'(fuente), 32'd1);
        chk("rr1 res", resultado_out, 32'h11111111);
        chk("rr1 ocupado", 32'(ocupado), 32'd1);
        sol[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rr1 wait ocupado", 32'(ocupado), 32'd1);
        end
        cyc();
        chk("rr2 ack", 32'(ack), 32'b100);
        chk("rr2 fuente", 32'(fuente), 32'd2);
        chk("rr2 res", resultado_out, 32'h22222222);
        sol = '0;
        repeat (3) cyc();
        chk("rr2 still busy", 32'(ocupado), 32'd1);
        cyc();
        chk("rr libre", 32'(ocupado), 32'd0);
        // owner refresh in place, expiry unchanged (ptr=0, source 1 wins)
        sol = 3'b010;
        cyc();
        chk("own ack", 32'(ack), 32'b010);
        sol = '0;
        cyc();
        dato1 = 32'hCAFE0001;
        sol = 3'b010;
        cyc();
        chk("refresh ack", 32'(ack), 32'b010);
        chk("refresh res", resultado_out, 32'hCAFE0001);
        chk("refresh fuente", 32'(fuente), 32'd1);
        sol = '0;
        cyc();
        chk("refresh busy", 32'(ocupado), 32'd1);
        chk("refresh ack off", 32'(ack), 32'd0);
        cyc();
        chk("refresh expiry", 32'(ocupado), 32'd0);
        // ptr=2: source 0 wins, source 2 waits for expiry
        sol = 3'b001;
        cyc();
        chk("w0 ack", 32'(ack), 32'b001);
        chk("w0 fuente", 32'(fuente), 32'd0);
        sol = 3'b100;
        dato2 = 32'h33333333;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("w2 waiting ack", 32'(ack), 32'd0);
            chk("w2 waiting fuente", 32'(fuente), 32'd0);
        end
        cyc();
        chk("w2 ack", 32'(ack), 32'b100);
        chk("w2 res", resultado_out, 32'h33333333);
        chk("w2 fuente", 32'(fuente), 32'd2);
        sol = 3'b011;
        repeat (3) cyc();
        cyc();
        chk("ptr0 ack", 32'(ack), 32'b001);
        chk("ptr0 res", resultado_out, 32'h12345678);
        sol = 3'b010;
        repeat (3) cyc();
        cyc();
        chk("ptr1 ack", 32'(ack), 32'b010);
        chk("ptr1 res", resultado_out, 32'hCAFE0001);
        sol = 3'b100;
        cyc();
        // asynchronous reset mid-hold
        #2 reinicio_n = 1'b0;
        #1 chk_reset("midreset");
        cyc();
        reinicio_n = 1'b1;
        cyc();
        chk("post ack", 32'(ack), 32'b100);
        chk("post fuente", 32'(fuente), 32'd2);
        chk("post res", resultado_out, 32'h33333333);
        // request kept high: masked for one cycle, then refreshed
        cyc();
        chk("mask ack", 32'(ack), 32'd0);
        cyc();
        chk("rearm ack", 32'(ack), 32'b100);
        sol = '0;
        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/display_arbitro.md
# display_arbitro

Shares the 8-digit seven-segment display between three value producers (operand A, operand B, calculator result) and sequences its refresh. Each producer requests with a level handshake. The arbiter grants round-robin, latches the 32-bit value into the word that drives the digit multiplexer, and holds it for a minimum visible time. It also generates the refresh strobe that advances the multiplexer's digit counter, so digit scanning runs at a controlled rate instead of the raw clock.

## Interface

- TIEMPO_MIN, default 50_000_000: minimum number of cycles a newly granted source stays displayed; legal range ≥ 1.
- DIV_REFRESCO, default 100_000: cycles between refresh strobes; legal range ≥ 1.
- reloj  in  1  system clock; all state changes on its rising edge.
- reinicio_n  in  1  asynchronous, active-low reset.
- sol  in  3  request per source (bit i = source i); level, held until ack[i].
- dato0, dato1, dato2  in  32 each  value offered by source 0/1/2; must be stable while its sol is high.
- ack  out  3  one-cycle grant pulse; at most one bit high per cycle.
- resultado_out  out  32  word currently displayed; feeds the digit multiplexer.
- fuente  out  2  index of the displayed source; 3 = none since reset.
- ocupado  out  1  high while the minimum-hold timer runs (state MOSTRAR).
- tick_refresco  out  1  one-cycle strobe every DIV_REFRESCO cycles.

## Operation

- Reset values (asserted asynchronously):
  - resultado_out = 0, fuente = 3, ack = 0, ocupado = 0, tick_refresco = 0.
  - State = LIBRE, round-robin pointer ptr = 0, hold timer = 0, prescaler = 0.
- State LIBRE:
  - If any sol bit is set (after masking, see the handshake rules below), grant the first set bit searching ptr, ptr+1, ptr+2 mod 3.
  - Latch that source's dato into resultado_out, set fuente, pulse ack for that source.
  - Load the timer with TIEMPO_MIN-1, set ptr = (grant+1) mod 3, go to MOSTRAR.
  - With no request, hold every output; the display keeps its last value.
- State MOSTRAR, timer ≠ 0:
  - Decrement the timer.
  - If sol[fuente] is set, the owner refreshes in place: latch its dato and pulse ack. The timer is not reloaded and ptr is unchanged.
  - Requests from other sources wait.
- State MOSTRAR, timer = 0:
  - With any masked request, arbitrate exactly as in LIBRE and stay in MOSTRAR with the timer reloaded. The owner may win only if it is next in round-robin order.
  - With no request, go to LIBRE.
- ocupado = 1 exactly while in MOSTRAR.
- Handshake rules:
  - A source's sol is masked during the cycle its own ack is high. This prevents a double grant before the source drops its request.
  - A request removed before ack is simply not granted; there is no error.
- Prescaler:
  - Free-running counter 0..DIV_REFRESCO-1, independent of the arbiter.
  - tick_refresco = 1 for the one cycle after the counter wraps from DIV_REFRESCO-1 to 0.
  - DIV_REFRESCO = 1 makes the strobe permanently high after the first cycle.
- Width rules:
  - Timer is clog2(TIEMPO_MIN) bits, minimum 1.
  - Prescaler is clog2(DIV_REFRESCO) bits, minimum 1.
  - Counters wrap; they never saturate.

## Timing

- Grant latency: a sol sampled high at edge k (LIBRE, or MOSTRAR with timer = 0) produces ack, resultado_out and fuente updated at edge k, visible in cycle k+1.
- The earliest next grant to a different source comes TIEMPO_MIN cycles after the previous one.
- Back-to-back grants to different sources with no LIBRE bubble occur when requests are pending at timer expiry.
- In-place refresh has 1-cycle latency and can repeat every 2 cycles, because the source's own ack masks it for one cycle.
- Simultaneous owner refresh and timer expiry: the expiry arbitration wins. The owner is served only by round-robin order.
- Reset asserted mid-hold: all state clears immediately, the display shows 0 and the grant in progress is lost. Sources must re-request after reset release.
- Reset release: first possible ack is at the first rising edge with reinicio_n high.

## Test plan

- Reset then idle, TIEMPO_MIN=4, DIV_REFRESCO=3 -> resultado_out=0, fuente=3, ack=0, tick_refresco pulses at cycles 3, 6, 9.
- sol=3'b001, dato0=32'h12345678 -> ack=001 one cycle later, resultado_out=32'h12345678, fuente=0, ocupado high 4 cycles, then LIBRE.
- sol=3'b111 held, each source drops sol after its ack -> grants in order 0, 1, 2, each 4 cycles apart, no LIBRE between.
- Source 1 owns the display, re-asserts sol[1] with dato1=32'hCAFE0001 mid-hold -> ack=010 next cycle, value updated, hold expiry unchanged.
- Source 0 granted, sol[2] raised at cycle 1 of the hold -> ack[2] only at timer expiry (4 cycles after ack[0]), ptr then points to 0.
- reinicio_n pulsed low during MOSTRAR -> all outputs return to reset values asynchronously. A pending sol is granted on the first edge after release.
